// File: rtl/jt12_slot_seq.sv
// Slot sequencer for the FM operator accumulator: rotating operator-group strobes,
// channel index, and per-channel alg/rl/pcm_en double-buffered and committed at frame start.
module jt12_slot_seq #(
    parameter int CHANNELS = 6
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cen,
    input  logic       wr_en,
    input  logic [2:0] wr_ch,
    input  logic [2:0] wr_alg,
    input  logic [1:0] wr_rl,
    input  logic       wr_pcm_en,
    output logic       wr_ack,
    output logic       s1_enters,
    output logic       s2_enters,
    output logic       s3_enters,
    output logic       s4_enters,
    output logic [2:0] ch,
    output logic       ch6op,
    output logic [2:0] alg,
    output logic [1:0] rl,
    output logic       pcm_en,
    output logic       frame
);

    if (CHANNELS < 2 || CHANNELS > 7) begin : g_bad_channels
        $error("jt12_slot_seq: CHANNELS must be in 2..7");
    end

    localparam logic [2:0] LAST_CH = 3'(CHANNELS - 1);

    // One-hot encoding so the strobes come straight off the state flops.
    typedef enum logic [3:0] {
        GRP_S1 = 4'b0001,
        GRP_S2 = 4'b0010,
        GRP_S3 = 4'b0100,
        GRP_S4 = 4'b1000
    } grp_e;

    grp_e       grp_q, grp_d, grp_nxt;
    logic [2:0] ch_q, ch_d, ch_nxt;
    logic       ch6op_q, ch6op_d;
    logic [2:0] alg_q, alg_d;
    logic [1:0] rl_q, rl_d;
    logic       pcm_q, pcm_d;
    logic       frame_q, frame_d;
    logic       ack_q, ack_d;

    logic [2:0] live_alg_q [CHANNELS];
    logic [2:0] live_alg_d [CHANNELS];
    logic [1:0] live_rl_q  [CHANNELS];
    logic [1:0] live_rl_d  [CHANNELS];
    logic       live_pcm_q, live_pcm_d;
    logic [2:0] sh_alg_q   [CHANNELS];
    logic [2:0] sh_alg_d   [CHANNELS];
    logic [1:0] sh_rl_q    [CHANNELS];
    logic [1:0] sh_rl_d    [CHANNELS];
    logic       sh_pcm_q, sh_pcm_d;

    logic wr_ok, wrap, commit;

    always_comb begin
        wr_ok  = wr_en && (wr_ch <= LAST_CH);
        wrap   = (ch_q == LAST_CH);
        commit = cen && wrap && (grp_q == GRP_S4);
        ch_nxt = wrap ? '0 : ch_q + 3'd1;

        case (grp_q)
            GRP_S1:  grp_nxt = GRP_S3;
            GRP_S3:  grp_nxt = GRP_S2;
            GRP_S2:  grp_nxt = GRP_S4;
            default: grp_nxt = GRP_S1;
        endcase

        grp_d      = grp_q;
        ch_d       = ch_q;
        ch6op_d    = ch6op_q;
        alg_d      = alg_q;
        rl_d       = rl_q;
        pcm_d      = pcm_q;
        frame_d    = 1'b0;
        ack_d      = wr_ok;
        live_pcm_d = commit ? sh_pcm_q : live_pcm_q;
        sh_pcm_d   = sh_pcm_q;

        // Commit reads the pre-edge shadow, so a write on the commit edge waits a frame.
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            live_alg_d[i] = commit ? sh_alg_q[i] : live_alg_q[i];
            live_rl_d[i]  = commit ? sh_rl_q[i]  : live_rl_q[i];
            sh_alg_d[i]   = sh_alg_q[i];
            sh_rl_d[i]    = sh_rl_q[i];
            if (wr_ok && wr_ch == 3'(i)) begin
                sh_alg_d[i] = wr_alg;
                sh_rl_d[i]  = wr_rl;
            end
        end
        if (wr_ok && wr_ch == LAST_CH) begin
            sh_pcm_d = wr_pcm_en;
        end

        if (cen) begin
            ch_d    = ch_nxt;
            grp_d   = wrap ? grp_nxt : grp_q;
            frame_d = commit;
            ch6op_d = (ch_nxt == LAST_CH);
            pcm_d   = (ch_nxt == LAST_CH) && live_pcm_d;
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                if (ch_nxt == 3'(i)) begin
                    alg_d = live_alg_d[i];
                    rl_d  = live_rl_d[i];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grp_q      <= GRP_S1;
            ch_q       <= '0;
            ch6op_q    <= 1'b0;
            alg_q      <= '0;
            rl_q       <= '1;
            pcm_q      <= 1'b0;
            frame_q    <= 1'b0;
            ack_q      <= 1'b0;
            live_pcm_q <= 1'b0;
            sh_pcm_q   <= 1'b0;
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                live_alg_q[i] <= '0;
                live_rl_q[i]  <= '1;
                sh_alg_q[i]   <= '0;
                sh_rl_q[i]    <= '1;
            end
        end else begin
            grp_q      <= grp_d;
            ch_q       <= ch_d;
            ch6op_q    <= ch6op_d;
            alg_q      <= alg_d;
            rl_q       <= rl_d;
            pcm_q      <= pcm_d;
            frame_q    <= frame_d;
            ack_q      <= ack_d;
            live_pcm_q <= live_pcm_d;
            sh_pcm_q   <= sh_pcm_d;
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                live_alg_q[i] <= live_alg_d[i];
                live_rl_q[i]  <= live_rl_d[i];
                sh_alg_q[i]   <= sh_alg_d[i];
                sh_rl_q[i]    <= sh_rl_d[i];
            end
        end
    end

    assign s1_enters = grp_q[0];
    assign s2_enters = grp_q[1];
    assign s3_enters = grp_q[2];
    assign s4_enters = grp_q[3];
    assign ch        = ch_q;
    assign ch6op     = ch6op_q;
    assign alg       = alg_q;
    assign rl        = rl_q;
    assign pcm_en    = pcm_q;
    assign frame     = frame_q;
    assign wr_ack    = ack_q;

endmodule

// File: tb/tb_jt12_slot_seq.sv
// Randomized bench for jt12_slot_seq against a slot-index/array reference model.
module tb_jt12_slot_seq;

    localparam int C = 6;
    localparam int SLOTS = 4 * C;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       cen = 1'b0;
    logic       wr_en = 1'b0;
    logic [2:0] wr_ch = '0;
    logic [2:0] wr_alg = '0;
    logic [1:0] wr_rl = '0;
    logic       wr_pcm_en = 1'b0;
    logic       wr_ack, s1_enters, s2_enters, s3_enters, s4_enters, ch6op, pcm_en, frame;
    logic [2:0] ch, alg;
    logic [1:0] rl;

    jt12_slot_seq #(.CHANNELS(C)) dut (
        .clk(clk), .rst_n(rst_n), .cen(cen), .wr_en(wr_en), .wr_ch(wr_ch),
        .wr_alg(wr_alg), .wr_rl(wr_rl), .wr_pcm_en(wr_pcm_en), .wr_ack(wr_ack),
        .s1_enters(s1_enters), .s2_enters(s2_enters), .s3_enters(s3_enters),
        .s4_enters(s4_enters), .ch(ch), .ch6op(ch6op), .alg(alg), .rl(rl),
        .pcm_en(pcm_en), .frame(frame)
    );

    always #5 clk = ~clk;

    logic [15:0] dut_v;
    assign dut_v = {wr_ack, s1_enters, s2_enters, s3_enters, s4_enters, ch, ch6op,
                    alg, rl, pcm_en, frame};

    // Reference model: slot index k in 0..SLOTS-1, group = order[k / C], channel = k % C.
    int         k;
    int         grp_order[4] = '{1, 3, 2, 4};
    logic [2:0] m_alg[C], s_alg[C];
    logic [1:0] m_rl[C], s_rl[C];
    logic       m_pcm, s_pcm, m_ack, m_frame;
    int         n_vec = 0;
    int         n_err = 0;

    function automatic void model_reset();
        k = 0; m_pcm = 0; s_pcm = 0; m_ack = 0; m_frame = 0;
        for (int i = 0; i < C; i++) begin
            m_alg[i] = 0; s_alg[i] = 0; m_rl[i] = 2'b11; s_rl[i] = 2'b11;
        end
    endfunction

    function automatic void model_edge();
        bit ok = wr_en && (int'(wr_ch) < C);
        bit commit = cen && (k == SLOTS - 1);
        if (commit) begin
            for (int i = 0; i < C; i++) begin
                m_alg[i] = s_alg[i]; m_rl[i] = s_rl[i];
            end
            m_pcm = s_pcm;
        end
        if (ok) begin
            s_alg[wr_ch] = wr_alg; s_rl[wr_ch] = wr_rl;
            if (int'(wr_ch) == C - 1) s_pcm = wr_pcm_en;
        end
        m_frame = commit;
        m_ack = ok;
        if (cen) k = (k + 1) % SLOTS;
    endfunction

    function automatic logic [15:0] exp_v();
        int c = k % C;
        int g = grp_order[k / C];
        logic [3:0] oh = '0;
        oh[4 - g] = 1'b1;
        return {m_ack, oh, 3'(c), c == C - 1, m_alg[c], m_rl[c],
                (c == C - 1) ? m_pcm : 1'b0, m_frame};
    endfunction

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_write(input logic [2:0] wch, input logic [2:0] walg,
                            input logic [1:0] wrl, input logic wpcm);
        wr_en = 1; wr_ch = wch; wr_alg = walg; wr_rl = wrl; wr_pcm_en = wpcm;
    endtask

    task automatic test_reset();
        #1 rst_n = 0;
        model_reset();
        #1;
        n_vec++;
        if (dut_v !== exp_v()) begin
            n_err++; $display("FAIL reset: got %h exp %h", dut_v, exp_v());
        end
        n_vec++;
        if ({s1_enters, s2_enters, s3_enters, s4_enters, ch, alg, rl, pcm_en, wr_ack, frame}
            !== {4'b1000, 3'd0, 3'd0, 2'b11, 1'b0, 1'b0, 1'b0}) begin
            n_err++; $display("FAIL reset_const: got %h", dut_v);
        end
        @(negedge clk) rst_n = 1;
    endtask

    task automatic test_sequence();
        cen = 1;
        for (int i = 1; i <= 48; i++) begin
            step();
            n_vec++;
            if (dut_v !== exp_v()) begin
                n_err++; $display("FAIL seq cyc %0d: got %h exp %h", i, dut_v, exp_v());
            end
            n_vec++;
            if ($countones({s1_enters, s2_enters, s3_enters, s4_enters}) != 1 ||
                frame !== (i % 24 == 0) || ch6op !== (ch == 3'd5)) begin
                n_err++;
                $display("FAIL seq_onehot_frame cyc %0d: grp %b frame %b ch6op %b ch %0d",
                         i, {s1_enters, s2_enters, s3_enters, s4_enters}, frame, ch6op, ch);
            end
        end
    endtask

    task automatic test_cen_toggle();
        for (int i = 0; i < 80; i++) begin
            cen = (i % 2 == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            step();
            n_vec++;
            if (dut_v !== exp_v()) begin
                n_err++; $display("FAIL cen_toggle cyc %0d: got %h exp %h", i, dut_v, exp_v());
            end
        end
    endtask

    task automatic test_write_midframe();
        bit seen_frame = 0;
        cen = 1;
        for (int i = 0; i < SLOTS && k != 9; i++) begin
            step();
            n_vec++;
            if (dut_v !== exp_v()) begin
                n_err++; $display("FAIL wr_mid_align: got %h exp %h", dut_v, exp_v());
            end
        end
        n_vec++;
        if (k != 9) begin
            n_err++; $display("FAIL wr_mid_reach: got k=%0d exp 9", k);
        end
        do_write(3'd2, 3'd5, 2'b01, 1'b0);
        for (int i = 0; i < 40; i++) begin
            step();
            wr_en = 0;
            if (frame) seen_frame = 1;
            n_vec++;
            if (dut_v !== exp_v()) begin
                n_err++; $display("FAIL wr_mid cyc %0d: got %h exp %h", i, dut_v, exp_v());
            end
            n_vec++;
            if ((i == 0 && wr_ack !== 1'b1) ||
                (ch == 3'd2 && {alg, rl} !== (seen_frame ? 5'b101_01 : 5'b000_11))) begin
                n_err++;
                $display("FAIL wr_mid_direct cyc %0d: ack %b alg %0d rl %b", i, wr_ack, alg, rl);
            end
        end
    endtask

    task automatic test_commit_collision();
        cen = 1;
        for (int i = 0; i < SLOTS && k != SLOTS - 1; i++) begin
            step();
            n_vec++;
            if (dut_v !== exp_v()) begin
                n_err++; $display("FAIL collide_align: got %h exp %h", dut_v, exp_v());
            end
        end
        do_write(3'd1, 3'd7, 2'b10, 1'b0);
        for (int i = 0; i < 50; i++) begin
            step();
            wr_en = 0;
            n_vec++;
            if (dut_v !== exp_v()) begin
                n_err++; $display("FAIL collide cyc %0d: got %h exp %h", i, dut_v, exp_v());
            end
        end
    endtask

    task automatic test_invalid_pcm();
        cen = 1;
        do_write(3'd6, 3'd3, 2'b00, 1'b1);
        step();
        n_vec++;
        if (wr_ack !== 1'b0 || dut_v !== exp_v()) begin
            n_err++; $display("FAIL bad_ch6: ack %b got %h exp %h", wr_ack, dut_v, exp_v());
        end
        do_write(3'd3, 3'd4, 2'b10, 1'b1);
        step();
        wr_en = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            n_vec++;
            if (dut_v !== exp_v() || pcm_en !== 1'b0) begin
                n_err++; $display("FAIL pcm_ch3 cyc %0d: got %h exp %h", i, dut_v, exp_v());
            end
        end
        do_write(3'd5, 3'd2, 2'b01, 1'b1);
        step();
        wr_en = 0;
        for (int i = 0; i < 60; i++) begin
            step();
            n_vec++;
            if (dut_v !== exp_v() || (pcm_en && !ch6op)) begin
                n_err++; $display("FAIL pcm_ch5 cyc %0d: got %h exp %h", i, dut_v, exp_v());
            end
        end
    endtask

    task automatic test_reset_midframe();
        cen = 1;
        for (int i = 0; i < 13; i++) begin
            if (i % 3 == 0)
                do_write(3'($urandom_range(0, C - 1)), 3'($urandom), 2'($urandom), 1'b1);
            else
                wr_en = 0;
            step();
            n_vec++;
            if (dut_v !== exp_v()) begin
                n_err++; $display("FAIL rst_mid_pre cyc %0d: got %h exp %h", i, dut_v, exp_v());
            end
        end
        wr_en = 0;
        rst_n = 0;
        model_reset();
        #1;
        n_vec++;
        if (dut_v !== exp_v()) begin
            n_err++; $display("FAIL rst_mid_now: got %h exp %h", dut_v, exp_v());
        end
        @(negedge clk) rst_n = 1;
        for (int i = 0; i < 60; i++) begin
            step();
            n_vec++;
            if (dut_v !== exp_v()) begin
                n_err++; $display("FAIL rst_mid_post cyc %0d: got %h exp %h", i, dut_v, exp_v());
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            cen = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 3) == 0)
                do_write(3'($urandom_range(0, 7)), 3'($urandom), 2'($urandom), 1'($urandom));
            else
                wr_en = 0;
            step();
            n_vec++;
            if (dut_v !== exp_v()) begin
                n_err++; $display("FAIL random cyc %0d: got %h exp %h", i, dut_v, exp_v());
            end
        end
        wr_en = 0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_sequence();
        test_cen_toggle();
        test_write_midframe();
        test_commit_collision();
        test_invalid_pcm();
        test_reset_midframe();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
